// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU issue stage and the ALU itself:
//   - ALU_* 4-bit control encodings (the ALU decodes these directly)
//   - MIPS opcode and R-type funct field values understood by the issue stage
//   - op_sel_e: operand-source select produced by the decoder
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // SEL_REG on operand 2 means rt, or rs when the decoder sets swap (shifts).
   typedef enum logic [2:0] {
      SEL_REG      = 3'd0,
      SEL_IMM_SEXT = 3'd1,
      SEL_IMM_ZEXT = 3'd2,
      SEL_SHAMT    = 3'd3,
      SEL_LUI      = 3'd4,
      SEL_ZERO     = 3'd5
   } op_sel_e;

endpackage

// File: rtl/alu_issue_decode.sv
// ---------------------------------------------------------------------------
// alu_issue_decode
// Purely combinational MIPS decode for the ALU issue stage.
//   i_instr    : 32-bit instruction word
//   o_alu_ctrl : ALU_* control
//   o_sel1     : operand 1 source (SEL_REG or SEL_ZERO)
//   o_sel2     : operand 2 source
//   o_swap     : shifts take the shifted value from rt (src1) and a variable
//                amount from rs (src2), i.e. register roles are swapped
//   o_wr_en    : result written back (already forced low for r0)
//   o_rd       : destination register number
//   o_illegal  : encoding not supported by this stage
// ---------------------------------------------------------------------------
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [3:0]  o_alu_ctrl,
   output op_sel_e     o_sel1,
   output op_sel_e     o_sel2,
   output logic        o_swap,
   output logic        o_wr_en,
   output logic [4:0]  o_rd,
   output logic        o_illegal
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [4:0] w_rt;
   logic [4:0] w_rd;
   logic [4:0] w_dest;
   logic       w_wr;
   logic       w_unused;

   assign w_op     = i_instr[31:26];
   assign w_funct  = i_instr[5:0];
   assign w_rt     = i_instr[20:16];
   assign w_rd     = i_instr[15:11];
   // rs number and shamt are consumed by the register file / operand mux.
   assign w_unused = ^{i_instr[25:21], i_instr[10:6]};

   // Opcode/funct decode; defaults describe the NOP used for unlisted encodings.
   always_comb begin
      o_alu_ctrl = ALU_ADD;
      o_sel1     = SEL_ZERO;
      o_sel2     = SEL_ZERO;
      o_swap     = 1'b0;
      w_dest     = 5'd0;
      w_wr       = 1'b0;
      o_illegal  = 1'b1;
      case (w_op)
         OP_RTYPE: begin
            o_illegal = 1'b0;
            o_sel1    = SEL_REG;
            o_sel2    = SEL_REG;
            w_dest    = w_rd;
            w_wr      = 1'b1;
            case (w_funct)
               FN_ADD, FN_ADDU: o_alu_ctrl = ALU_ADD;
               FN_SUB, FN_SUBU: o_alu_ctrl = ALU_SUB;
               FN_AND:          o_alu_ctrl = ALU_AND;
               FN_OR:           o_alu_ctrl = ALU_OR;
               FN_XOR:          o_alu_ctrl = ALU_XOR;
               FN_SLT:          o_alu_ctrl = ALU_SLT;
               FN_SLTU:         o_alu_ctrl = ALU_SLTU;
               FN_SLL:  begin o_alu_ctrl = ALU_SLL; o_swap = 1'b1; o_sel2 = SEL_SHAMT; end
               FN_SRL:  begin o_alu_ctrl = ALU_SRL; o_swap = 1'b1; o_sel2 = SEL_SHAMT; end
               FN_SRA:  begin o_alu_ctrl = ALU_SRA; o_swap = 1'b1; o_sel2 = SEL_SHAMT; end
               FN_SLLV: begin o_alu_ctrl = ALU_SLL; o_swap = 1'b1; end
               FN_SRLV: begin o_alu_ctrl = ALU_SRL; o_swap = 1'b1; end
               FN_SRAV: begin o_alu_ctrl = ALU_SRA; o_swap = 1'b1; end
               default: begin
                  o_illegal = 1'b1;
                  o_sel1    = SEL_ZERO;
                  o_sel2    = SEL_ZERO;
                  w_dest    = 5'd0;
                  w_wr      = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SLTI, OP_SLTIU: begin
            o_illegal  = 1'b0;
            o_alu_ctrl = (w_op == OP_SLTI)  ? ALU_SLT  :
                         (w_op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            o_sel1     = SEL_REG;
            o_sel2     = SEL_IMM_SEXT;
            w_dest     = w_rt;
            w_wr       = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            o_illegal  = 1'b0;
            o_alu_ctrl = (w_op == OP_ANDI) ? ALU_AND :
                         (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            o_sel1     = SEL_REG;
            o_sel2     = SEL_IMM_ZEXT;
            w_dest     = w_rt;
            w_wr       = 1'b1;
         end
         OP_LUI: begin
            o_illegal  = 1'b0;
            o_sel2     = SEL_LUI;
            w_dest     = w_rt;
            w_wr       = 1'b1;
         end
         OP_SW: begin
            o_illegal  = 1'b0;
            o_sel1     = SEL_REG;
            o_sel2     = SEL_IMM_SEXT;
         end
         OP_BEQ, OP_BNE: begin
            o_illegal  = 1'b0;
            o_alu_ctrl = ALU_SUB;
            o_sel1     = SEL_REG;
            o_sel2     = SEL_REG;
         end
         default: begin
            o_illegal  = 1'b1;
         end
      endcase
   end

   assign o_rd    = w_dest;
   assign o_wr_en = w_wr & (w_dest != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// ID/EX issue stage: decodes a MIPS instruction, forms ALU operands and holds
// them in a one-entry valid/ready pipeline register feeding the ALU.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_valid / o_ready   : upstream handshake (instr + register values)
//   i_instr, i_rs_val, i_rt_val : instruction and its register operands
//   i_flush             : squash the held op and any incoming op
//   o_valid / i_ready   : downstream (ALU) handshake
//   o_src1, o_src2, o_alu_ctrl, o_wr_en, o_rd : registered ALU inputs
//   o_illegal           : unsupported encoding flag, present only when the
//                         macro ALU_ISSUE_ILLEGAL_EN is defined
// ---------------------------------------------------------------------------
module alu_issue
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_instr,
   input  logic [WIDTH-1:0] i_rs_val,
   input  logic [WIDTH-1:0] i_rt_val,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_src1,
   output logic [WIDTH-1:0] o_src2,
   output logic [3:0]       o_alu_ctrl,
   output logic             o_wr_en,
   output logic [4:0]       o_rd
`ifdef ALU_ISSUE_ILLEGAL_EN
   ,
   output logic             o_illegal
`endif
);

   logic [3:0]       w_ctrl;
   op_sel_e          w_sel1;
   op_sel_e          w_sel2;
   logic             w_swap;
   logic             w_wr_en;
   logic [4:0]       w_rd;
   logic             w_dec_illegal;
   logic [15:0]      w_imm;
   logic [WIDTH-1:0] w_src1;
   logic [WIDTH-1:0] w_src2;
   logic             w_load;

   logic             r_valid;
   logic [WIDTH-1:0] r_src1;
   logic [WIDTH-1:0] r_src2;
   logic [3:0]       r_ctrl;
   logic             r_wr_en;
   logic [4:0]       r_rd;

   alu_issue_decode u_decode (
      .i_instr    (i_instr),
      .o_alu_ctrl (w_ctrl),
      .o_sel1     (w_sel1),
      .o_sel2     (w_sel2),
      .o_swap     (w_swap),
      .o_wr_en    (w_wr_en),
      .o_rd       (w_rd),
      .o_illegal  (w_dec_illegal)
   );

   assign w_imm   = i_instr[15:0];
   assign o_ready = ~r_valid | i_ready;
   // Flush wins over an incoming instruction.
   assign w_load  = i_valid & o_ready & ~i_flush;

   // Operand 1 source mux.
   always_comb begin
      w_src1 = {WIDTH{1'b0}};
      case (w_sel1)
         SEL_REG: w_src1 = w_swap ? i_rt_val : i_rs_val;
         default: w_src1 = {WIDTH{1'b0}};
      endcase
   end

   // Operand 2 source mux with immediate/shamt extension.
   always_comb begin
      w_src2 = {WIDTH{1'b0}};
      case (w_sel2)
         SEL_REG:      w_src2 = w_swap ? i_rs_val : i_rt_val;
         SEL_IMM_SEXT: w_src2 = {{(WIDTH-16){w_imm[15]}}, w_imm};
         SEL_IMM_ZEXT: w_src2 = {{(WIDTH-16){1'b0}}, w_imm};
         SEL_SHAMT:    w_src2 = {{(WIDTH-5){1'b0}}, i_instr[10:6]};
         SEL_LUI:      w_src2 = {w_imm, {(WIDTH-16){1'b0}}};
         default:      w_src2 = {WIDTH{1'b0}};
      endcase
   end

   // Valid flag: flush clears, load sets, consume without reload clears.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Payload registers capture only on accept, so a stalled op stays bit-stable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_src1  <= {WIDTH{1'b0}};
         r_src2  <= {WIDTH{1'b0}};
         r_ctrl  <= 4'd0;
         r_wr_en <= 1'b0;
         r_rd    <= 5'd0;
      end else if (w_load) begin
         r_src1  <= w_src1;
         r_src2  <= w_src2;
         r_ctrl  <= w_ctrl;
         r_wr_en <= w_wr_en;
         r_rd    <= w_rd;
      end else begin
         r_src1  <= r_src1;
         r_src2  <= r_src2;
         r_ctrl  <= r_ctrl;
         r_wr_en <= r_wr_en;
         r_rd    <= r_rd;
      end
   end

`ifdef ALU_ISSUE_ILLEGAL_EN
   logic r_illegal;

   // Illegal flag travels with the payload.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_illegal <= 1'b0;
      end else if (w_load) begin
         r_illegal <= w_dec_illegal;
      end else begin
         r_illegal <= r_illegal;
      end
   end

   assign o_illegal = r_illegal;
`else
   logic w_unused_illegal;
   assign w_unused_illegal = w_dec_illegal;
`endif

   assign o_valid    = r_valid;
   assign o_src1     = r_src1;
   assign o_src2     = r_src2;
   assign o_alu_ctrl = r_ctrl;
   assign o_wr_en    = r_wr_en;
   assign o_rd       = r_rd;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Self-checking bench for alu_issue: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// Define ALU_ISSUE_ILLEGAL_EN consistently for bench and RTL to cover o_illegal.
// ---------------------------------------------------------------------------
module tb_alu_issue;

   typedef struct packed {
      logic [31:0] s1;
      logic [31:0] s2;
      logic [3:0]  c;
      logic        we;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instr;
   logic [31:0] i_rs_val;
   logic [31:0] i_rt_val;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_src1;
   logic [31:0] o_src2;
   logic [3:0]  o_alu_ctrl;
   logic        o_wr_en;
   logic [4:0]  o_rd;
`ifdef ALU_ISSUE_ILLEGAL_EN
   logic        o_illegal;
`endif

   int   total = 0;
   int   bad   = 0;
   logic m_valid;
   exp_t m_e;

   alu_issue #(.WIDTH(32)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_instr    (i_instr),
      .i_rs_val   (i_rs_val),
      .i_rt_val   (i_rt_val),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_src1     (o_src1),
      .o_src2     (o_src2),
      .o_alu_ctrl (o_alu_ctrl),
      .o_wr_en    (o_wr_en),
      .o_rd       (o_rd)
`ifdef ALU_ISSUE_ILLEGAL_EN
      ,
      .o_illegal  (o_illegal)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // What the ALU must see for an instruction, straight from the decode rules.
   function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] se;
      logic [31:0] ze;
      logic [31:0] sh;
      op = ins[31:26];
      fn = ins[5:0];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0000, ins[15:0]};
      sh = {27'd0, ins[10:6]};
      e = '0;
      e.ill = 1'b0;
      if (op == 6'h00) begin
         e.we = 1'b1; e.rd = ins[15:11]; e.s1 = rs; e.s2 = rt;
         case (fn)
            6'h20, 6'h21: e.c = 4'd0;
            6'h22, 6'h23: e.c = 4'd1;
            6'h24: e.c = 4'd2;
            6'h25: e.c = 4'd3;
            6'h26: e.c = 4'd4;
            6'h2A: e.c = 4'd8;
            6'h2B: e.c = 4'd9;
            6'h00: begin e.c = 4'd5; e.s1 = rt; e.s2 = sh; end
            6'h02: begin e.c = 4'd6; e.s1 = rt; e.s2 = sh; end
            6'h03: begin e.c = 4'd7; e.s1 = rt; e.s2 = sh; end
            6'h04: begin e.c = 4'd5; e.s1 = rt; e.s2 = rs; end
            6'h06: begin e.c = 4'd6; e.s1 = rt; e.s2 = rs; end
            6'h07: begin e.c = 4'd7; e.s1 = rt; e.s2 = rs; end
            default: begin e = '0; e.ill = 1'b1; end
         endcase
      end else begin
         e.s1 = rs; e.rd = ins[20:16]; e.we = 1'b1;
         case (op)
            6'h08, 6'h09, 6'h23: begin e.c = 4'd0; e.s2 = se; end
            6'h0A: begin e.c = 4'd8; e.s2 = se; end
            6'h0B: begin e.c = 4'd9; e.s2 = se; end
            6'h0C: begin e.c = 4'd2; e.s2 = ze; end
            6'h0D: begin e.c = 4'd3; e.s2 = ze; end
            6'h0E: begin e.c = 4'd4; e.s2 = ze; end
            6'h0F: begin e.c = 4'd0; e.s1 = 32'd0; e.s2 = {ins[15:0], 16'h0000}; end
            6'h2B: begin e.c = 4'd0; e.s2 = se; e.we = 1'b0; end
            6'h04, 6'h05: begin e.c = 4'd1; e.s2 = rt; e.we = 1'b0; end
            default: begin e = '0; e.ill = 1'b1; end
         endcase
      end
      if (e.rd == 5'd0) e.we = 1'b0;
      return e;
   endfunction

   task automatic check_outputs();
      chk("valid", 32'(o_valid), 32'(m_valid));
      if (m_valid) begin
         chk("src1", o_src1, m_e.s1);
         chk("src2", o_src2, m_e.s2);
         chk("ctrl", 32'(o_alu_ctrl), 32'(m_e.c));
         chk("wr_en", 32'(o_wr_en), 32'(m_e.we));
         if (m_e.we) chk("rd", 32'(o_rd), 32'(m_e.rd));
`ifdef ALU_ISSUE_ILLEGAL_EN
         chk("illegal", 32'(o_illegal), 32'(m_e.ill));
`endif
      end
   endtask

   // Drive one cycle from a negedge, advance the model at the posedge,
   // and compare at the following negedge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl, input logic rdy);
      logic acc;
      i_valid = v; i_instr = ins; i_rs_val = rs; i_rt_val = rt; i_flush = fl; i_ready = rdy;
      #1;
      chk("ready", 32'(o_ready), 32'(!m_valid || rdy));
      @(posedge i_clk);
      acc = !m_valid || rdy;
      if (fl) m_valid = 1'b0;
      else if (v && acc) begin m_valid = 1'b1; m_e = ref_dec(ins, rs, rt); end
      else if (rdy) m_valid = 1'b0;
      @(negedge i_clk);
      check_outputs();
   endtask

   logic [5:0]  ops [14] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
   logic [5:0]  fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h3F};

   initial begin
      logic [31:0] ins;
      logic [31:0] op_a;
      logic [31:0] op_b;
      int          k;
      m_valid = 1'b0; m_e = '0;
      i_rst = 1'b1; i_valid = 1'b0; i_instr = 32'd0; i_rs_val = 32'd0;
      i_rt_val = 32'd0; i_flush = 1'b0; i_ready = 1'b0;
      repeat (2) @(negedge i_clk);
      // reset state
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_src1", o_src1, 32'd0);
      chk("rst_src2", o_src2, 32'd0);
      chk("rst_ctrl", 32'(o_alu_ctrl), 32'd0);
      chk("rst_wr_en", 32'(o_wr_en), 32'd0);
      chk("rst_rd", 32'(o_rd), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk("rst_illegal", 32'(o_illegal), 32'd0);
`endif
      i_rst = 1'b0;

      // ADDI r2,r1,-1
      cycle(1'b1, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd77, 1'b0, 1'b1);
      chk("addi_valid", 32'(o_valid), 32'd1);
      chk("addi_src1", o_src1, 32'd5);
      chk("addi_src2", o_src2, 32'hFFFF_FFFF);
      chk("addi_ctrl", 32'(o_alu_ctrl), 32'd0);
      chk("addi_rd", 32'(o_rd), 32'd2);
      chk("addi_wr_en", 32'(o_wr_en), 32'd1);
      // SRA rd=3, rt value 0x8000_0000, shamt 4
      cycle(1'b1, {6'h00, 5'd0, 5'd4, 5'd3, 5'd4, 6'h03}, 32'h55, 32'h8000_0000, 1'b0, 1'b1);
      chk("sra_src1", o_src1, 32'h8000_0000);
      chk("sra_src2", o_src2, 32'd4);
      chk("sra_ctrl", 32'(o_alu_ctrl), 32'd7);
      // ORI imm 0x8001
      cycle(1'b1, {6'h0D, 5'd1, 5'd5, 16'h8001}, 32'h10, 32'h20, 1'b0, 1'b1);
      chk("ori_src2", o_src2, 32'h0000_8001);
      chk("ori_ctrl", 32'(o_alu_ctrl), 32'd3);
      // LUI imm 0x1234
      cycle(1'b1, {6'h0F, 5'd0, 5'd6, 16'h1234}, 32'd99, 32'd98, 1'b0, 1'b1);
      chk("lui_src1", o_src1, 32'd0);
      chk("lui_src2", o_src2, 32'h1234_0000);

      // back-to-back with a 3-cycle downstream stall
      op_a = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
      op_b = {6'h00, 5'd3, 5'd4, 5'd8, 5'd0, 6'h22};
      cycle(1'b1, op_a, 32'hA1, 32'hA2, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         cycle(1'b1, op_b, 32'hB1, 32'hB2, 1'b0, 1'b0);
         chk("stall_ready", 32'(o_ready), 32'd0);
         chk("stall_src1", o_src1, 32'hA1);
         chk("stall_rd", 32'(o_rd), 32'd7);
      end
      cycle(1'b1, op_b, 32'hB1, 32'hB2, 1'b0, 1'b1);
      chk("b2b_valid", 32'(o_valid), 32'd1);
      chk("b2b_src1", o_src1, 32'hB1);
      chk("b2b_ctrl", 32'(o_alu_ctrl), 32'd1);

      // flush with held op and incoming op: neither is emitted
      cycle(1'b1, op_a, 32'hC1, 32'hC2, 1'b0, 1'b0);
      cycle(1'b1, op_a, 32'hD1, 32'hD2, 1'b1, 1'b0);
      chk("flush_valid", 32'(o_valid), 32'd0);
      cycle(1'b0, op_a, 32'hE1, 32'hE2, 1'b0, 1'b1);
      chk("flush_after", 32'(o_valid), 32'd0);

      // unlisted opcode 0x3F
      cycle(1'b1, 32'hFFFF_FFFF, 32'h1111, 32'h2222, 1'b0, 1'b1);
      chk("ill_valid", 32'(o_valid), 32'd1);
      chk("ill_wr_en", 32'(o_wr_en), 32'd0);
      chk("ill_ctrl", 32'(o_alu_ctrl), 32'd0);
      chk("ill_src1", o_src1, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk("ill_flag", 32'(o_illegal), 32'd1);
`endif

      // asynchronous reset while an op is stalled
      cycle(1'b1, op_b, 32'hF1, 32'hF2, 1'b0, 1'b1);
      cycle(1'b0, op_b, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(o_valid), 32'd1);
      #2 i_rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(o_valid), 32'd0);
      chk("async_rst_src1", o_src1, 32'd0);
      m_valid = 1'b0; m_e = '0;
      @(negedge i_clk);
      i_rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         k = $urandom_range(0, 13);
         ins = $urandom;
         if (k == 13) ins[31:26] = 6'($urandom);
         else ins[31:26] = ops[k];
         if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 15)];
         cycle(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
